// File: rtl/imm_ext_pipe.sv
// LC-3 immediate-field extractor with a 2-entry in-order output FIFO.
// Extension is computed at enqueue time; outputs come only from registered state.
module imm_ext_pipe #(
  parameter int OUT_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_instr,
  input  logic [2:0]               in_sel,
  input  logic                     in_zext,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [2:0] SEL_IMM5  = 3'd0;
  localparam logic [2:0] SEL_OFF6  = 3'd1;
  localparam logic [2:0] SEL_PCO9  = 3'd2;
  localparam logic [2:0] SEL_PCO11 = 3'd3;
  localparam logic [2:0] SEL_TRAP8 = 3'd4;

  logic [1:0]           count;
  logic [OUT_WIDTH-1:0] head_data;
  logic [OUT_WIDTH-1:0] tail_data;
  logic                 head_err;
  logic                 tail_err;
  logic                 push;
  logic                 pop;
  logic [OUT_WIDTH-1:0] ext_data;
  logic                 ext_err;
  logic                 sext_on;

  // Opcode bits never feed any immediate field.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[15:11];

  // Handshake decoded purely from the registered occupancy.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign sext_on = ~in_zext;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_sel)
      SEL_IMM5:  ext_data = {{(OUT_WIDTH-5){in_instr[4] & sext_on}},   in_instr[4:0]};
      SEL_OFF6:  ext_data = {{(OUT_WIDTH-6){in_instr[5] & sext_on}},   in_instr[5:0]};
      SEL_PCO9:  ext_data = {{(OUT_WIDTH-9){in_instr[8] & sext_on}},   in_instr[8:0]};
      SEL_PCO11: ext_data = {{(OUT_WIDTH-11){in_instr[10] & sext_on}}, in_instr[10:0]};
      SEL_TRAP8: ext_data = {{(OUT_WIDTH-8){1'b0}},                   in_instr[7:0]};
      default:   ext_err  = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= EMPTY;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head is the presented entry; tail only holds the second entry when FULL.
  // NOTE: the two storage slots are reset because out_data must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
    end else begin
      if (pop && (count == FULL)) begin
        head_data <= tail_data;
        head_err  <= tail_err;
      end else if (push && ((count == EMPTY) || pop)) begin
        head_data <= ext_data;
        head_err  <= ext_err;
      end
      if (push && !pop && (count == ONE)) begin
        tail_data <= ext_data;
        tail_err  <= ext_err;
      end
    end
  end

  // Saturating count of accepted illegal selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && ext_err && (err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign out_data = head_data;
  assign out_err  = head_err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: driver queues model results on accept,
// an independent monitor checks handshake state and pops/compares outputs.
module tb_imm_ext_pipe;

  localparam int OW     = 16;
  localparam int EW     = 8;
  localparam int CNTMAX = (1 << EW) - 1;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic [2:0]    in_sel;
  logic          in_zext;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_err;
  logic [EW-1:0] err_cnt;

  exp_t q[$];
  int   exp_errcnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   ordy = 1'b1;

  imm_ext_pipe #(.OUT_WIDTH(OW), .ERR_CNT_WIDTH(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_sel    (in_sel),
    .in_zext   (in_zext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field width by select; value taken modulo 2^w, then sign-adjusted arithmetically.
  function automatic exp_t ref_model(input logic [15:0] instr, input logic [2:0] sel, input logic zext);
    exp_t r;
    int   w;
    int   field;
    r.data = '0;
    r.err  = 1'b0;
    case (sel)
      3'd0:    w = 5;
      3'd1:    w = 6;
      3'd2:    w = 9;
      3'd3:    w = 11;
      3'd4:    w = 8;
      default: w = 0;
    endcase
    if (w == 0) begin
      r.err = 1'b1;
      return r;
    end
    field = int'(instr) % (1 << w);
    if (sel == 3'd4 || zext || field < (1 << (w - 1)))
      r.data = 16'(field);
    else
      r.data = 16'(field - (1 << w) + 65536);
    return r;
  endfunction

  // Monitor: status vs model occupancy, then compare/pop the head.
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      check("in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
      if (out_valid && q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(q[0].data));
        check("out_err", {31'd0, out_err}, {31'd0, q[0].err});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // One driver cycle; optional reset pulse inside the low clock phase.
  task automatic step(input bit v, input logic [15:0] instr, input logic [2:0] sel,
                      input logic z, input bit do_rst, output bit acc);
    exp_t r;
    @(negedge clk);
    in_valid  = v;
    in_instr  = instr;
    in_sel    = sel;
    in_zext   = z;
    out_ready = ordy;
    #3;
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      q.delete();
      exp_errcnt = 0;
      #1;
      rst_n = 1'b1;
      #1;
    end
    acc = v && in_ready;
    if (acc) begin
      r = ref_model(instr, sel, z);
      q.push_back(r);
      if (r.err && exp_errcnt < CNTMAX) exp_errcnt++;
    end
  endtask

  task automatic send(input logic [15:0] instr, input logic [2:0] sel, input logic z);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      step(1'b1, instr, sel, z, 1'b0, acc);
      t++;
    end
    if (!acc) check("send_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      step(1'b0, 16'($urandom), 3'($urandom), 1'($urandom), 1'b0, acc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    ordy = 1'b1;
    while (q.size() != 0 && t < 50) begin
      idle(1);
      t++;
    end
    idle(1);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_sel    = '0;
    in_zext   = 1'b0;
    out_ready = 1'b1;
    #5;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_err", {31'd0, out_err}, 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed: imm5 of all-ones, PCoffset9 sext then zext, trapvect8 forced zext.
    ordy = 1'b1;
    send(16'h001F, 3'd0, 1'b0);
    idle(2);
    send(16'h0100, 3'd2, 1'b0);
    send(16'h0100, 3'd2, 1'b1);
    send(16'hF0FF, 3'd4, 1'b0);
    send(16'h07FF, 3'd3, 1'b0);
    send(16'h0400, 3'd3, 1'b0);
    drain();

    // Backpressure: two accepted, third held until a pop frees a slot.
    ordy = 1'b0;
    send(16'h0020, 3'd1, 1'b0);
    send(16'h0001, 3'd1, 1'b0);
    step(1'b1, 16'h003F, 3'd1, 1'b0, 1'b0, acc);
    check("full_blocks_push", {31'd0, acc}, 32'd0);
    idle(2);
    ordy = 1'b1;
    send(16'h003F, 3'd1, 1'b0);
    drain();

    // Illegal selects saturate the error counter.
    ordy = 1'b1;
    for (int i = 0; i < 300; i++) send(16'($urandom), 3'd6, 1'($urandom));
    drain();
    check("err_cnt_saturated", 32'(err_cnt), 32'(CNTMAX));

    // Reset from FULL between edges; the push on the first edge after release survives alone.
    ordy = 1'b0;
    send(16'h0011, 3'd0, 1'b0);
    send(16'h0022, 3'd7, 1'b0);
    step(1'b1, 16'h0010, 3'd0, 1'b0, 1'b1, acc);
    check("post_reset_accept", {31'd0, acc}, 32'd1);
    idle(1);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      ordy = ($urandom % 4) != 0;
      step(1'($urandom % 2), 16'($urandom), 3'($urandom), 1'($urandom), 1'b0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 16: output data width; legal range 12..32.
REQ-002 SHALL have parameter ERR_CNT_WIDTH, default 8: width of the illegal-select counter; legal range 1..16.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: producer offers a request.
REQ-006 SHALL have port in_ready, output, 1: block can accept a request this cycle.
REQ-007 SHALL have port in_instr, input, 16: LC-3 instruction word.
REQ-008 SHALL have port in_sel, input, 3: field select (encoding in REQ-014).
REQ-009 SHALL have port in_zext, input, 1: 1 forces zero-extend instead of sign-extend.
REQ-010 SHALL have port out_valid, output, 1: head entry is valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the head entry.
REQ-012 SHALL have port out_data, output, OUT_WIDTH: extended immediate at the head.
REQ-013 SHALL have ports out_err (output, 1: head entry came from an illegal select) and err_cnt (output, ERR_CNT_WIDTH: count of accepted illegal selects).

Function
REQ-014 SHALL decode in_sel as: 0 = imm5 [4:0]; 1 = offset6 [5:0]; 2 = PCoffset9 [8:0]; 3 = PCoffset11 [10:0]; 4 = trapvect8 [7:0]; 5..7 = illegal.
REQ-015 SHALL sign-extend the selected field to OUT_WIDTH by replicating its MSB when in_zext=0, and SHALL zero-fill all upper bits when in_zext=1.
REQ-016 SHALL always zero-extend trapvect8 (sel 4), regardless of in_zext.
REQ-017 SHALL produce out_data = 0 and out_err = 1 for an illegal select; out_err SHALL be 0 for legal selects.
REQ-018 SHALL compute extension at enqueue time and store {data, err} in a 2-entry in-order FIFO.
REQ-019 SHALL keep an occupancy state count in {EMPTY=0, ONE=1, FULL=2}.
REQ-020 SHALL drive in_ready = (count != FULL) and out_valid = (count != EMPTY); both are decoded from registered state only, with no combinational path from in_valid/out_ready.
REQ-021 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready.
REQ-022 SHALL apply these count transitions: push only = +1; pop only = -1; push and pop together = unchanged (legal in ONE only); neither = unchanged.
REQ-023 SHALL have latency 1: a request pushed at edge N into EMPTY appears on out_data/out_err with out_valid=1 after edge N.
REQ-024 SHALL hold out_data and out_err stable while out_valid=1 and out_ready=0.
REQ-025 SHALL ignore in_instr, in_sel and in_zext when push=0.
REQ-026 SHALL, when FULL, keep in_ready=0 and drop no data; after a pop from FULL, in_ready SHALL be 1 in the following cycle.
REQ-027 SHALL increment err_cnt by 1 on each push with an illegal select, and SHALL saturate err_cnt at all-ones (no wrap).
REQ-028 SHALL make out_data depend only on stored state (no combinational in-to-out bypass).

Reset
REQ-029 SHALL, while rst_n=0 and independent of clk, force count=EMPTY, out_valid=0, out_data=0, out_err=0 and err_cnt=0.
REQ-030 SHALL drive in_ready=1 during and after reset.
REQ-031 SHALL discard all FIFO contents when reset is asserted mid-operation, and SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL pass this scenario: sel=0, instr=0x001F, zext=0, out_ready=1 -> one cycle later out_valid=1, out_data=0xFFFF, out_err=0.
REQ-033 SHALL pass this scenario: sel=2, instr=0x0100, zext=0, then zext=1 -> out_data 0xFF00, then 0x0100, in order.
REQ-034 SHALL pass this scenario: sel=4, instr=0xF0FF, zext=0 -> out_data=0x00FF.
REQ-035 SHALL pass this scenario: out_ready=0 with 3 back-to-back pushes of sel=1 (instr 0x0020, 0x0001, 0x003F) -> in_ready=0 after 2 accepts; the third request is held by the producer; then out_ready=1 -> outputs 0xFFE0, 0x0001, 0xFFFF in order with no loss or duplication.
REQ-036 SHALL pass this scenario: 300 pushes of sel=6 with ERR_CNT_WIDTH=8 -> every output is out_data=0, out_err=1, and err_cnt stops at 255.
REQ-037 SHALL pass this scenario: FIFO FULL, rst_n pulsed low between clock edges -> out_valid=0, in_ready=1, err_cnt=0 immediately; the next push is delivered alone.
